// File: rtl/notepad_text_buffer.sv
// Text cursor and character-RAM writer for the notepad: takes ASCII over valid/ready,
// writes glyph codes at the cursor, and blanks the whole screen after reset or form-feed.
module notepad_text_buffer #(
   parameter int COLS   = 80,
   parameter int ROWS   = 60,
   parameter int COL_W  = 7,
   parameter int ROW_W  = 6,
   parameter int ADDR_W = 13
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              in_valid,
   input  logic [6:0]        in_ascii,
   output logic              in_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [6:0]        wr_data,
   output logic [COL_W-1:0]  cursor_col,
   output logic [ROW_W-1:0]  cursor_row,
   output logic              clearing
);

   localparam int               CELLS    = COLS * ROWS;
   localparam logic [ADDR_W:0]  CLR_DONE = (ADDR_W+1)'(CELLS);
   localparam logic [COL_W-1:0] COL_MAX  = COL_W'(COLS - 1);
   localparam logic [ROW_W-1:0] ROW_MAX  = ROW_W'(ROWS - 1);
   localparam logic [6:0]       ASC_BS   = 7'd8;
   localparam logic [6:0]       ASC_FF   = 7'd12;
   localparam logic [6:0]       ASC_CR   = 7'd13;
   localparam logic [6:0]       ASC_SP   = 7'd32;
   localparam logic [6:0]       ASC_DEL  = 7'd127;

   typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_BUSY} state_e;

   state_e             state_q, state_d;
   // One bit wider than the address so the terminal count CELLS is representable.
   logic [ADDR_W:0]    cnt_q, cnt_d;
   logic [COL_W-1:0]   col_q, col_d;
   logic [ROW_W-1:0]   row_q, row_d;
   logic               wr_en_q, wr_en_d;
   logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
   logic [6:0]         wr_data_q, wr_data_d;
   logic               in_ready_q, in_ready_d;
   logic               clearing_q, clearing_d;
   logic               accept;
   logic [ROW_W-1:0]   row_inc;

   function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] r,
                                                   input logic [COL_W-1:0] c);
      return ADDR_W'(r) * ADDR_W'(COLS) + ADDR_W'(c);
   endfunction

   assign accept  = in_valid & in_ready_q;
   assign row_inc = (row_q == ROW_MAX) ? '0 : row_q + 1'b1;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      col_d      = col_q;
      row_d      = row_q;
      wr_en_d    = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      in_ready_d = in_ready_q;
      clearing_d = clearing_q;
      unique case (state_q)
         S_CLEAR: begin
            if (cnt_q == CLR_DONE) begin
               state_d    = S_IDLE;
               clearing_d = 1'b0;
               in_ready_d = 1'b1;
            end else begin
               wr_en_d   = 1'b1;
               wr_addr_d = cnt_q[ADDR_W-1:0];
               wr_data_d = ASC_SP;
               cnt_d     = cnt_q + 1'b1;
            end
         end
         S_IDLE: begin
            if (accept) begin
               state_d    = S_BUSY;
               in_ready_d = 1'b0;
               if (in_ascii == ASC_FF) begin
                  state_d    = S_CLEAR;
                  clearing_d = 1'b1;
                  cnt_d      = '0;
                  col_d      = '0;
                  row_d      = '0;
               end else if (in_ascii == ASC_BS) begin
                  // Backspace at the home cell is swallowed without touching the screen.
                  if (col_q != '0 || row_q != '0) begin
                     if (col_q == '0) begin
                        col_d = COL_MAX;
                        row_d = row_q - 1'b1;
                     end else begin
                        col_d = col_q - 1'b1;
                     end
                     wr_en_d   = 1'b1;
                     wr_addr_d = cell_addr(row_d, col_d);
                     wr_data_d = ASC_SP;
                  end
               end else if (in_ascii == ASC_CR) begin
                  col_d = '0;
                  row_d = row_inc;
               end else if (in_ascii >= ASC_SP && in_ascii != ASC_DEL) begin
                  wr_en_d   = 1'b1;
                  wr_addr_d = cell_addr(row_q, col_q);
                  wr_data_d = in_ascii;
                  if (col_q == COL_MAX) begin
                     col_d = '0;
                     row_d = row_inc;
                  end else begin
                     col_d = col_q + 1'b1;
                  end
               end
            end
         end
         S_BUSY: begin
            state_d    = S_IDLE;
            in_ready_d = 1'b1;
         end
         default: begin
            state_d    = S_CLEAR;
            clearing_d = 1'b1;
            in_ready_d = 1'b0;
            cnt_d      = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q    <= S_CLEAR;
         cnt_q      <= '0;
         col_q      <= '0;
         row_q      <= '0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         in_ready_q <= 1'b0;
         clearing_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         col_q      <= col_d;
         row_q      <= row_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         in_ready_q <= in_ready_d;
         clearing_q <= clearing_d;
      end
   end

   assign in_ready   = in_ready_q;
   assign wr_en      = wr_en_q;
   assign wr_addr    = wr_addr_q;
   assign wr_data    = wr_data_q;
   assign cursor_col = col_q;
   assign cursor_row = row_q;
   assign clearing   = clearing_q;

endmodule

// File: tb/tb_notepad_text_buffer.sv
// Randomized bench for notepad_text_buffer: a linear-position screen model feeds an expected-write
// queue that an independent monitor drains on every observed RAM write.
module tb_notepad_text_buffer;

   localparam int COLS  = 80;
   localparam int ROWS  = 60;
   localparam int CELLS = COLS * ROWS;

   logic        clk;
   logic        resetn;
   logic        in_valid;
   logic [6:0]  in_ascii;
   logic        in_ready;
   logic        wr_en;
   logic [12:0] wr_addr;
   logic [6:0]  wr_data;
   logic [6:0]  cursor_col;
   logic [5:0]  cursor_row;
   logic        clearing;

   notepad_text_buffer dut (
      .clk        (clk),
      .resetn     (resetn),
      .in_valid   (in_valid),
      .in_ascii   (in_ascii),
      .in_ready   (in_ready),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .cursor_col (cursor_col),
      .cursor_row (cursor_row),
      .clearing   (clearing)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int addr;
      int data;
      bit clr;
   } wr_t;

   wr_t exp_q[$];
   int  n_cmp = 0;
   int  n_bad = 0;
   int  pos   = 0;     // cursor as a linear cell index row*COLS+col
   int  last_wait = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic void push_w(input int a, input int d, input bit c);
      wr_t e;
      e.addr = a;
      e.data = d;
      e.clr  = c;
      exp_q.push_back(e);
   endfunction

   function automatic void push_clear();
      for (int a = 0; a < CELLS; a++) push_w(a, 32, 1'b1);
   endfunction

   function automatic void model(input int ch);
      if (ch == 12) begin
         push_clear();
         pos = 0;
      end else if (ch == 8) begin
         if (pos > 0) begin
            pos--;
            push_w(pos, 32, 1'b0);
         end
      end else if (ch == 13) begin
         pos = ((pos / COLS + 1) % ROWS) * COLS;
      end else if (ch >= 32 && ch <= 126) begin
         push_w(pos, ch, 1'b0);
         pos = (pos + 1) % CELLS;
      end
   endfunction

   // Monitor: every observed write must match the oldest expected write.
   initial begin
      wr_t e;
      forever begin
         @(negedge clk);
         if (wr_en === 1'b1) begin
            chk("write_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("wr_addr", wr_addr, e.addr);
               chk("wr_data", wr_data, e.data);
               chk("clearing_on_write", clearing, e.clr);
            end
         end
      end
   end

   // Called #1 after a posedge; leaves in_valid high and returns #1 after the accept edge.
   task automatic send(input logic [6:0] ch);
      int w;
      in_ascii = ch;
      in_valid = 1'b1;
      w = 0;
      @(negedge clk);
      while (in_ready !== 1'b1 && w < 10000) begin
         w++;
         @(negedge clk);
      end
      chk("ready_before_accept", in_ready, 1);
      model(int'(ch));
      @(posedge clk);
      #1;
      last_wait = w;
      chk("ready_low_after_accept", in_ready, 0);
      chk("cursor_col", cursor_col, pos % COLS);
      chk("cursor_row", cursor_row, pos / COLS);
      chk("clearing_after_accept", clearing, ch == 7'd12);
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_clear();
      int n;
      n = 0;
      while (clearing !== 1'b0 && n < CELLS + 100) begin
         @(negedge clk);
         n++;
      end
      chk("clear_done_in_time", clearing, 0);
      chk("ready_after_clear", in_ready, 1);
      chk("col_after_clear", cursor_col, 0);
      chk("row_after_clear", cursor_row, 0);
      chk("clear_writes_drained", exp_q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset();
      chk("rst_wr_en", wr_en, 0);
      chk("rst_wr_addr", wr_addr, 0);
      chk("rst_wr_data", wr_data, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_col", cursor_col, 0);
      chk("rst_row", cursor_row, 0);
      chk("rst_clearing", clearing, 1);
   endtask

   task automatic goto_cell(input int c, input int r);
      int guard;
      guard = 0;
      while (pos != r * COLS + c && guard < 300) begin
         if (pos / COLS != r || pos % COLS > c) send(7'd13);
         else send(7'($urandom_range(126, 32)));
         guard++;
      end
      in_valid = 1'b0;
      chk("goto_col", cursor_col, c);
      chk("goto_row", cursor_row, r);
   endtask

   task automatic random_ops(input int n);
      int sel;
      logic [6:0] ch;
      for (int i = 0; i < n; i++) begin
         sel = $urandom_range(99, 0);
         if (sel < 50)      ch = 7'($urandom_range(126, 32));
         else if (sel < 65) ch = 7'd8;
         else if (sel < 75) ch = 7'd13;
         else begin
            ch = 7'($urandom_range(127, 0));
            if (ch == 7'd12) ch = 7'd127;
         end
         send(ch);
         if ($urandom_range(1, 0) == 0) idle($urandom_range(3, 0));
      end
      in_valid = 1'b0;
   endtask

   initial begin
      int n;
      resetn   = 1'b0;
      in_valid = 1'b0;
      in_ascii = '0;
      repeat (3) @(posedge clk);
      #1;
      check_reset();
      exp_q.delete();
      push_clear();
      pos = 0;
      resetn = 1'b1;
      wait_clear();

      // single 'A' with a one-cycle valid
      send(7'd65);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("ready_back_after_busy", in_ready, 1);

      // held-valid burst of 81 printables starting at row 1
      send(7'd13);
      for (int i = 0; i < 81; i++) begin
         send(7'($urandom_range(126, 32)));
         if (i > 0) chk("alternate_cycle_accept", last_wait, 1);
      end
      idle(2);

      // wrap from the last cell, then Enter on the last row
      goto_cell(79, 59);
      send(7'd90);
      goto_cell(5, 59);
      send(7'd13);
      in_valid = 1'b0;
      chk("enter_wrap_col", cursor_col, 0);
      chk("enter_wrap_row", cursor_row, 0);

      // backspace corners
      send(7'd8);
      send(7'd13);
      send(7'd8);
      in_valid = 1'b0;
      chk("bs_wrap_col", cursor_col, 79);
      chk("bs_wrap_row", cursor_row, 0);

      random_ops(300);

      // form feed mid-screen
      goto_cell(10, 3);
      send(7'd12);
      in_valid = 1'b0;
      wait_clear();

      // reset in the middle of a clear
      send(7'd12);
      in_valid = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(wr_en === 1'b1 && wr_addr == 13'd2000) && n < 6000);
      chk("reached_addr_2000", wr_addr, 2000);
      resetn = 1'b0;
      @(posedge clk);
      #1;
      check_reset();
      exp_q.delete();
      push_clear();
      pos = 0;
      resetn = 1'b1;
      wait_clear();

      random_ops(100);
      idle(4);
      chk("final_queue_empty", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
